// File: rtl/uart_receiver_if.sv
// Consumer-facing side of the UART receiver: received word, status flags
// and the read acknowledge that retires DataReady.
`timescale 1ns/1ps
interface uart_receiver_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] Data;
    logic                 DataReady;
    logic                 FramingError;
    logic                 ParityError;
    logic                 OverrunError;
    logic                 ReadAck;

    modport master (
        output Data, DataReady, FramingError, ParityError, OverrunError,
        input  ReadAck
    );

    modport slave (
        input  Data, DataReady, FramingError, ParityError, OverrunError,
        output ReadAck
    );
endinterface

// File: rtl/uart_receiver.sv
// Oversampled UART receiver: 2-flop line synchronizer, start-glitch rejection,
// optional parity, framing/overrun detection and break hold-off.
`timescale 1ns/1ps
module uart_receiver #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic Clock,
    input  logic ResetN,
    input  logic SamplingTick,
    input  logic SerialIn,
    input  logic ParityEnable,
    input  logic ParityOdd,
    output logic Busy,
    uart_receiver_if.master rx
);
    localparam int TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, BREAK_WAIT
    } state_t;

    logic                 sync_meta_q, rxs_q;
    state_t               state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_en_q, par_en_d;
    logic                 par_odd_q, par_odd_d;
    logic                 perr_cand_q, perr_cand_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 ready_q, ready_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;
    logic                 oerr_q, oerr_d;
    logic                 done;
    logic                 centre;

    // Synchronizer resets to the idle line level so reset release never fakes a start bit
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            sync_meta_q <= 1'b1;
            rxs_q       <= 1'b1;
        end else begin
            sync_meta_q <= SerialIn;
            rxs_q       <= sync_meta_q;
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q     <= IDLE;
            tick_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            par_en_q    <= 1'b0;
            par_odd_q   <= 1'b0;
            perr_cand_q <= 1'b0;
            data_q      <= '0;
            ready_q     <= 1'b0;
            ferr_q      <= 1'b0;
            perr_q      <= 1'b0;
            oerr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            par_en_q    <= par_en_d;
            par_odd_q   <= par_odd_d;
            perr_cand_q <= perr_cand_d;
            data_q      <= data_d;
            ready_q     <= ready_d;
            ferr_q      <= ferr_d;
            perr_q      <= perr_d;
            oerr_q      <= oerr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        par_en_d    = par_en_q;
        par_odd_d   = par_odd_q;
        perr_cand_d = perr_cand_q;
        data_d      = data_q;
        ready_d     = ready_q;
        ferr_d      = ferr_q;
        perr_d      = perr_q;
        oerr_d      = oerr_q;
        done        = 1'b0;
        centre      = SamplingTick && (tick_q == TICK_LAST);

        unique case (state_q)
            IDLE: begin
                if (SamplingTick && !rxs_q) begin
                    state_d   = START;
                    tick_d    = '0;
                    bit_d     = '0;
                    par_en_d  = ParityEnable;
                    par_odd_d = ParityOdd;
                end
            end
            START: begin
                if (SamplingTick) begin
                    if (tick_q == TICK_HALF) begin
                        state_d = rxs_q ? IDLE : DATA;
                        tick_d  = '0;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            DATA: begin
                if (centre) begin
                    tick_d  = '0;
                    shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else if (SamplingTick) begin
                    tick_d = tick_q + TW'(1);
                end
            end
            PARITY: begin
                if (centre) begin
                    tick_d      = '0;
                    perr_cand_d = ((^shift_q) ^ rxs_q) != par_odd_q;
                    state_d     = STOP;
                end else if (SamplingTick) begin
                    tick_d = tick_q + TW'(1);
                end
            end
            STOP: begin
                if (centre) begin
                    tick_d  = '0;
                    done    = 1'b1;
                    state_d = rxs_q ? IDLE : BREAK_WAIT;
                end else if (SamplingTick) begin
                    tick_d = tick_q + TW'(1);
                end
            end
            BREAK_WAIT: begin
                if (SamplingTick && rxs_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A completing frame takes priority over a coincident read acknowledge
        if (done) begin
            data_d  = shift_q;
            ferr_d  = ~rxs_q;
            perr_d  = par_en_q & perr_cand_q;
            oerr_d  = ready_q & ~rx.ReadAck;
            ready_d = 1'b1;
        end else if (rx.ReadAck) begin
            ready_d = 1'b0;
        end
    end

    assign Busy            = (state_q != IDLE);
    assign rx.Data         = data_q;
    assign rx.DataReady    = ready_q;
    assign rx.FramingError = ferr_q;
    assign rx.ParityError  = perr_q;
    assign rx.OverrunError = oerr_q;
endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: frames are driven bit by bit on a
// 4-clock sampling tick (16 ticks per bit) and checked against hand values.
`timescale 1ns/1ps
module tb_uart_receiver;
    logic Clock = 1'b0;
    logic ResetN, SamplingTick, SerialIn, ParityEnable, ParityOdd, Busy;
    int   checks = 0;
    int   errors = 0;

    uart_receiver_if #(.DATA_BITS(8)) rx_if ();

    uart_receiver #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .Clock        (Clock),
        .ResetN       (ResetN),
        .SamplingTick (SamplingTick),
        .SerialIn     (SerialIn),
        .ParityEnable (ParityEnable),
        .ParityOdd    (ParityOdd),
        .Busy         (Busy),
        .rx           (rx_if.master)
    );

    always #5 Clock = ~Clock;

    initial begin
        SamplingTick = 1'b0;
        forever begin
            repeat (3) @(posedge Clock);
            #1 SamplingTick = 1'b1;
            @(posedge Clock);
            #1 SamplingTick = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    task automatic wait_tick();
        @(posedge Clock);
        while (!SamplingTick) @(posedge Clock);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) wait_tick();
    endtask

    task automatic send_bit(input logic b);
        SerialIn = b;
        wait_ticks(16);
    endtask

    task automatic pulse_ack();
        rx_if.ReadAck = 1'b1;
        @(posedge Clock);
        #1 rx_if.ReadAck = 1'b0;
    endtask

    task automatic idle_line();
        SerialIn = 1'b1;
        wait_ticks(16);
    endtask

    // Stop level is left on the line; ack_done pulses ReadAck in the stop-sample cycle
    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pb,
                              input logic sb, input int stop_bits, input logic ack_done);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (pe) send_bit(pb);
        SerialIn = sb;
        if (ack_done) begin
            wait_ticks(8);
            @(posedge SamplingTick);
            rx_if.ReadAck = 1'b1;
            @(posedge Clock);
            #1 rx_if.ReadAck = 1'b0;
            wait_ticks(7);
        end else begin
            wait_ticks(16 * stop_bits);
        end
    endtask

    function automatic logic [3:0] flags();
        return {rx_if.DataReady, rx_if.FramingError, rx_if.ParityError, rx_if.OverrunError};
    endfunction

    task automatic test_reset();
        ResetN = 1'b0; SerialIn = 1'b1; ParityEnable = 1'b0; ParityOdd = 1'b0;
        rx_if.ReadAck = 1'b0;
        repeat (4) @(posedge Clock);
        #1;
        checks++;
        if (rx_if.Data !== 8'h00) begin
            errors++; $display("FAIL reset_data got %h exp %h", rx_if.Data, 8'h00);
        end
        checks++;
        if (flags() !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got %b exp %b", flags(), 4'b0000);
        end
        checks++;
        if (Busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy got %b exp %b", Busy, 1'b0);
        end
        #3 ResetN = 1'b1;
        wait_ticks(16);
    endtask

    task automatic test_8n1();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1, 1'b0);
        idle_line();
        checks++;
        if (rx_if.Data !== 8'hA5) begin
            errors++; $display("FAIL 8n1_data got %h exp %h", rx_if.Data, 8'hA5);
        end
        checks++;
        if (flags() !== 4'b1000) begin
            errors++; $display("FAIL 8n1_flags got %b exp %b", flags(), 4'b1000);
        end
        checks++;
        if (Busy !== 1'b0) begin
            errors++; $display("FAIL 8n1_busy got %b exp %b", Busy, 1'b0);
        end
        pulse_ack();
        checks++;
        if (rx_if.DataReady !== 1'b0) begin
            errors++; $display("FAIL 8n1_ack_clears got %b exp %b", rx_if.DataReady, 1'b0);
        end
        pulse_ack();
        checks++;
        if ({rx_if.Data, flags()} !== {8'hA5, 4'b0000}) begin
            errors++; $display("FAIL 8n1_idle_ack got %h exp %h", {rx_if.Data, flags()}, {8'hA5, 4'b0000});
        end
    endtask

    task automatic test_parity();
        ParityEnable = 1'b1; ParityOdd = 1'b0;
        send_frame(8'h37, 1'b1, 1'b0, 1'b1, 1, 1'b0);
        idle_line();
        checks++;
        if (rx_if.Data !== 8'h37) begin
            errors++; $display("FAIL even_bad_data got %h exp %h", rx_if.Data, 8'h37);
        end
        checks++;
        if (flags() !== 4'b1010) begin
            errors++; $display("FAIL even_bad_flags got %b exp %b", flags(), 4'b1010);
        end
        pulse_ack();
        send_frame(8'h37, 1'b1, 1'b1, 1'b1, 1, 1'b0);
        idle_line();
        checks++;
        if (flags() !== 4'b1000) begin
            errors++; $display("FAIL even_good_flags got %b exp %b", flags(), 4'b1000);
        end
        pulse_ack();
        ParityOdd = 1'b1;
        send_frame(8'h37, 1'b1, 1'b0, 1'b1, 1, 1'b0);
        idle_line();
        checks++;
        if (flags() !== 4'b1000) begin
            errors++; $display("FAIL odd_good_flags got %b exp %b", flags(), 4'b1000);
        end
        pulse_ack();
        send_frame(8'h37, 1'b1, 1'b1, 1'b1, 1, 1'b0);
        idle_line();
        checks++;
        if (flags() !== 4'b1010) begin
            errors++; $display("FAIL odd_bad_flags got %b exp %b", flags(), 4'b1010);
        end
        pulse_ack();
        ParityEnable = 1'b0; ParityOdd = 1'b0;
    endtask

    task automatic test_glitch();
        SerialIn = 1'b0;
        wait_tick();
        checks++;
        if (Busy !== 1'b1) begin
            errors++; $display("FAIL glitch_busy_rise got %b exp %b", Busy, 1'b1);
        end
        wait_ticks(3);
        idle_line();
        checks++;
        if (Busy !== 1'b0) begin
            errors++; $display("FAIL glitch_busy_fall got %b exp %b", Busy, 1'b0);
        end
        checks++;
        if ({rx_if.Data, rx_if.DataReady} !== {8'h37, 1'b0}) begin
            errors++; $display("FAIL glitch_no_output got %h exp %h", {rx_if.Data, rx_if.DataReady}, {8'h37, 1'b0});
        end
    endtask

    task automatic test_break();
        send_frame(8'h00, 1'b0, 1'b0, 1'b0, 3, 1'b0);
        checks++;
        if ({rx_if.Data, flags()} !== {8'h00, 4'b1100}) begin
            errors++; $display("FAIL break_frame got %h exp %h", {rx_if.Data, flags()}, {8'h00, 4'b1100});
        end
        checks++;
        if (Busy !== 1'b1) begin
            errors++; $display("FAIL break_busy_hold got %b exp %b", Busy, 1'b1);
        end
        SerialIn = 1'b1;
        wait_ticks(2);
        checks++;
        if (Busy !== 1'b0) begin
            errors++; $display("FAIL break_release got %b exp %b", Busy, 1'b0);
        end
        idle_line();
        pulse_ack();
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1, 1'b0);
        idle_line();
        checks++;
        if ({rx_if.Data, flags()} !== {8'h55, 4'b1000}) begin
            errors++; $display("FAIL after_break got %h exp %h", {rx_if.Data, flags()}, {8'h55, 4'b1000});
        end
    endtask

    task automatic test_back_to_back();
        pulse_ack();
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1, 1'b0);
        idle_line();
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1, 1'b0);
        idle_line();
        checks++;
        if ({rx_if.Data, flags()} !== {8'h22, 4'b1001}) begin
            errors++; $display("FAIL overrun got %h exp %h", {rx_if.Data, flags()}, {8'h22, 4'b1001});
        end
        pulse_ack();
        checks++;
        if (flags() !== 4'b0001) begin
            errors++; $display("FAIL ack_keeps_error got %b exp %b", flags(), 4'b0001);
        end
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1, 1'b0);
        idle_line();
        checks++;
        if ({rx_if.Data, flags()} !== {8'h11, 4'b1000}) begin
            errors++; $display("FAIL overrun_cleared got %h exp %h", {rx_if.Data, flags()}, {8'h11, 4'b1000});
        end
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1, 1'b1);
        idle_line();
        checks++;
        if ({rx_if.Data, flags()} !== {8'h22, 4'b1000}) begin
            errors++; $display("FAIL ack_coincide got %h exp %h", {rx_if.Data, flags()}, {8'h22, 4'b1000});
        end
    endtask

    task automatic test_reset_midframe();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        #3 ResetN = 1'b0;
        #1;
        checks++;
        if ({rx_if.Data, flags(), Busy} !== {8'h00, 4'b0000, 1'b0}) begin
            errors++; $display("FAIL midframe_reset got %h exp %h", {rx_if.Data, flags(), Busy}, {8'h00, 4'b0000, 1'b0});
        end
        repeat (3) @(posedge Clock);
        #3 ResetN = 1'b1;
        wait_ticks(40);
        checks++;
        if ({flags(), Busy} !== 5'b00000) begin
            errors++; $display("FAIL post_reset_idle got %b exp %b", {flags(), Busy}, 5'b00000);
        end
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1, 1'b0);
        idle_line();
        checks++;
        if ({rx_if.Data, flags()} !== {8'h3C, 4'b1000}) begin
            errors++; $display("FAIL post_reset_frame got %h exp %h", {rx_if.Data, flags()}, {8'h3C, 4'b1000});
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_glitch();
        test_break();
        test_back_to_back();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter: DATA_BITS, default 8, number of data bits per frame (5..8).
REQ-002 Parameter: OVERSAMPLE, default 16, SamplingTick pulses per bit period.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset; the ports are Clock and ResetN.
REQ-004 Clock  input  1  system clock; all state changes on its rising edge.
REQ-005 ResetN  input  1  asynchronous active-low reset.
REQ-006 SamplingTick  input  1  one-Clock-cycle enable pulse at OVERSAMPLE x baud rate.
REQ-007 SerialIn  input  1  asynchronous serial line, idle high.
REQ-008 ParityEnable  input  1  1 = frame carries a parity bit after the data bits.
REQ-009 ParityOdd  input  1  1 = odd parity, 0 = even parity; ignored when ParityEnable=0.
REQ-010 ReadAck  input  1  one-cycle pulse from the consumer, clears DataReady.
REQ-011 Data  output  DATA_BITS  last received word, LSB received first.
REQ-012 DataReady  output  1  level, set on frame completion, cleared by ReadAck.
REQ-013 FramingError  output  1  stop bit sampled low in the last frame.
REQ-014 ParityError  output  1  parity mismatch in the last frame.
REQ-015 OverrunError  output  1  a frame completed while DataReady was still 1.
REQ-016 Busy  output  1  high whenever the state is not IDLE.

Function
REQ-017 SerialIn SHALL pass through a 2-flop synchronizer; all logic uses only the synchronized value RxS.
REQ-018 States SHALL be IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
REQ-019 The tick counter (0..OVERSAMPLE-1) and the bit counter SHALL advance only in cycles where SamplingTick=1.
REQ-020 IDLE->START: on a SamplingTick cycle with RxS=0; tick counter cleared.
REQ-021 START: at tick count OVERSAMPLE/2-1 (7), if RxS=1 it is a glitch -> IDLE with no output change; else -> DATA, tick counter cleared.
REQ-022 DATA: each bit is sampled when the tick counter reaches OVERSAMPLE-1 (bit centre); the bit shifts in LSB-first; after DATA_BITS bits -> PARITY if ParityEnable, else -> STOP.
REQ-023 PARITY: sample at the bit centre; ParityError candidate = (XOR of data bits XOR sampled bit) != ParityOdd; -> STOP.
REQ-024 STOP: sample at the bit centre; frame completes at this sample.
REQ-025 Frame completion SHALL, in the next Clock cycle, load Data, FramingError (=~stop sample), ParityError (0 if ParityEnable=0), and set DataReady=1.
REQ-026 OverrunError SHALL load 1 at completion if DataReady was 1 and ReadAck was not asserted in the completion cycle, else 0; Data SHALL be overwritten in all cases.
REQ-027 When ReadAck and completion coincide, completion wins: DataReady stays 1 and OverrunError=0.
REQ-028 ReadAck while DataReady=0 SHALL have no effect; ReadAck SHALL NOT clear the error flags.
REQ-029 After completion: stop sample 1 -> IDLE; stop sample 0 -> BREAK_WAIT, which holds until RxS=1 on a SamplingTick cycle and then -> IDLE.
REQ-030 ParityEnable and ParityOdd SHALL be sampled on the IDLE->START transition and held for the frame.
REQ-031 SerialIn changes between SamplingTick pulses SHALL NOT affect state except through the sample points.

Reset
REQ-032 ResetN=0 SHALL immediately force state IDLE, all counters to 0, the synchronizer flops to 1, Data=0, and DataReady, FramingError, ParityError, OverrunError and Busy to 0.
REQ-033 Reset mid-frame SHALL discard the partial frame; after release, reception starts only on the next falling edge.

Verification
REQ-034 8N1, byte 0xA5, ParityEnable=0, then ReadAck -> Data=0xA5, DataReady=1, all errors 0; DataReady=0 one cycle after ReadAck.
REQ-035 8E1, byte 0x37 with parity bit 0 (wrong) -> Data=0x37, ParityError=1; same byte with parity bit 1 -> ParityError=0.
REQ-036 Low pulse of 4 sampling ticks on an idle line -> returns to IDLE, DataReady stays 0, Busy pulses then drops.
REQ-037 Byte 0x00 with stop bit 0 held low for 3 bit times -> FramingError=1, Busy stays high until the line returns high, then a following 0x55 frame is received correctly.
REQ-038 Two frames 0x11 then 0x22 with no ReadAck -> Data=0x22, OverrunError=1; repeat with ReadAck in the second completion cycle -> OverrunError=0, DataReady=1.
REQ-039 ResetN asserted after the 4th data bit of 0xFF -> all outputs 0 at once; the next full frame 0x3C is received with Data=0x3C and no errors.
